// File: rtl/ctl_master_if.sv
// Host request/response port and configuration ring port of ctl_master.
interface ctl_master_if;
   localparam int unsigned FLIT_W = 134;
   localparam int unsigned MID_W  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ERR_W  = 2;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [MID_W-1:0]  req_dst_mid;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [ERR_W-1:0]  rsp_err;
   logic [DATA_W-1:0] rsp_rdata;
   logic [FLIT_W-1:0] cout_ctl_data;
   logic              cout_ctl_data_wr;
   logic              cin_ctl_ready;
   logic [FLIT_W-1:0] cin_ctl_data;
   logic              cin_ctl_data_wr;
   logic              cout_ctl_ready;

   // Register-access master view.
   modport master (
      input  req_valid, req_write, req_dst_mid, req_addr, req_wdata,
      input  cin_ctl_ready, cin_ctl_data, cin_ctl_data_wr,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
      output cout_ctl_data, cout_ctl_data_wr, cout_ctl_ready
   );

   // Host and ring environment view.
   modport slave (
      output req_valid, req_write, req_dst_mid, req_addr, req_wdata,
      output cin_ctl_ready, cin_ctl_data, cin_ctl_data_wr,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
      input  cout_ctl_data, cout_ctl_data_wr, cout_ctl_ready
   );
endinterface

// File: rtl/ctl_master.sv
// Configuration-ring register access master: turns host read/write requests
// into two-flit packets and matches the returning read responses.
module ctl_master #(
   parameter logic [7:0]  OWN_MID = 8'd1,
   parameter logic [15:0] TIMEOUT = 16'd1024
) (
   input logic          clk,
   input logic          rst,
   ctl_master_if.master bus
);
   localparam int unsigned FLIT_W = 134;
   localparam int unsigned SEQ_W  = 12;
   localparam int unsigned MID_W  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TMR_W  = 16;
   localparam int unsigned ERR_W  = 2;

   localparam logic [1:0]       TAG_HDR     = 2'b01;
   localparam logic [1:0]       TAG_TAIL    = 2'b10;
   localparam logic [3:0]       TYPE_RD     = 4'b0001;
   localparam logic [3:0]       TYPE_WR     = 4'b0010;
   localparam logic [3:0]       TYPE_RSP    = 4'b1011;
   localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [ERR_W-1:0] ERR_NORSP   = 2'b10;

   typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_TAIL, WAIT_RSP} state_t;

   state_t            state_q, state_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              write_q, write_d;
   logic [MID_W-1:0]  dst_q, dst_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              got_hdr_q, got_hdr_d;
   logic              no_rsp_q, no_rsp_d;
   logic [DATA_W-1:0] cap_q, cap_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ERR_W-1:0]  rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [FLIT_W-1:0] cout_data_q, cout_data_d;
   logic              cout_wr_q, cout_wr_d;

   logic [FLIT_W-1:0] cin;
   logic [FLIT_W-1:0] hdr_flit;
   logic              accept, in_wait, is_hdr, is_tail;
   logic              rsp_match, norsp_match, done_tail, timeout_hit;
   logic              unused_cin_bits;

   assign cin             = bus.cin_ctl_data;
   assign unused_cin_bits = ^{cin[131:128], cin[95:32]};

   assign accept  = bus.req_valid && req_ready_q;
   assign in_wait = (state_q == WAIT_RSP);
   assign is_hdr  = bus.cin_ctl_data_wr && (cin[133:132] == TAG_HDR);
   assign is_tail = bus.cin_ctl_data_wr && (cin[133:132] == TAG_TAIL);

   // A genuine read response addressed back to us for the outstanding seq.
   assign rsp_match = in_wait && is_hdr && (cin[127:124] == TYPE_RSP) &&
                      (cin[123:112] == seq_q) && (cin[103:96] == OWN_MID) &&
                      (cin[111:104] == dst_q);
   // Our own read request travelled the whole ring without being claimed.
   assign norsp_match = in_wait && is_hdr && (cin[126:124] == 3'b001) &&
                        (cin[123:112] == seq_q) && (cin[111:104] == OWN_MID) &&
                        (cin[103:96] == dst_q);
   assign done_tail   = in_wait && is_tail && (got_hdr_q || no_rsp_q);
   assign timeout_hit = in_wait && (timer_q == TIMEOUT);

   assign hdr_flit = {TAG_HDR, 4'b0000, write_q ? TYPE_WR : TYPE_RD, seq_q,
                      OWN_MID, dst_q, addr_q, 32'h0, write_q ? wdata_q : 32'h0};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept) state_d = SEND_HDR;
         SEND_HDR:  if (bus.cin_ctl_ready) state_d = SEND_TAIL;
         SEND_TAIL: if (bus.cin_ctl_ready) state_d = write_q ? IDLE : WAIT_RSP;
         WAIT_RSP:  if (done_tail || timeout_hit) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Output and datapath next values; flits and pulses default to idle.
   always_comb begin
      seq_d       = seq_q;
      write_d     = write_q;
      dst_d       = dst_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      timer_d     = timer_q;
      got_hdr_d   = got_hdr_q;
      no_rsp_d    = no_rsp_q;
      cap_d       = cap_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      cout_data_d = '0;
      cout_wr_d   = 1'b0;
      req_ready_d = (state_d == IDLE);
      case (state_q)
         IDLE: begin
            if (accept) begin
               seq_d   = seq_q + SEQ_W'(1);
               write_d = bus.req_write;
               dst_d   = bus.req_dst_mid;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
            end
         end
         SEND_HDR: begin
            if (bus.cin_ctl_ready) begin
               cout_data_d = hdr_flit;
               cout_wr_d   = 1'b1;
            end
         end
         SEND_TAIL: begin
            if (bus.cin_ctl_ready) begin
               cout_data_d = {TAG_TAIL, 132'h0};
               cout_wr_d   = 1'b1;
               if (write_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = ERR_OK;
                  rsp_rdata_d = '0;
               end else begin
                  timer_d   = '0;
                  got_hdr_d = 1'b0;
                  no_rsp_d  = 1'b0;
               end
            end
         end
         WAIT_RSP: begin
            timer_d = timer_q + TMR_W'(1);
            if (rsp_match) begin
               got_hdr_d = 1'b1;
               no_rsp_d  = 1'b0;
               cap_d     = cin[31:0];
            end else if (norsp_match) begin
               got_hdr_d = 1'b0;
               no_rsp_d  = 1'b1;
            end
            // A completing tail takes priority over a simultaneous timeout.
            if (done_tail) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = got_hdr_q ? ERR_OK : ERR_NORSP;
               rsp_rdata_d = got_hdr_q ? cap_q : '0;
            end else if (timeout_hit) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = ERR_TIMEOUT;
               rsp_rdata_d = '0;
            end
         end
         default: ;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_q       <= '0;
         write_q     <= 1'b0;
         dst_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         timer_q     <= '0;
         got_hdr_q   <= 1'b0;
         no_rsp_q    <= 1'b0;
         cap_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= '0;
         rsp_rdata_q <= '0;
         cout_data_q <= '0;
         cout_wr_q   <= 1'b0;
      end else begin
         seq_q       <= seq_d;
         write_q     <= write_d;
         dst_q       <= dst_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         timer_q     <= timer_d;
         got_hdr_q   <= got_hdr_d;
         no_rsp_q    <= no_rsp_d;
         cap_q       <= cap_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         cout_data_q <= cout_data_d;
         cout_wr_q   <= cout_wr_d;
      end
   end

   assign bus.req_ready        = req_ready_q;
   assign bus.rsp_valid        = rsp_valid_q;
   assign bus.rsp_err          = rsp_err_q;
   assign bus.rsp_rdata        = rsp_rdata_q;
   assign bus.cout_ctl_data    = cout_data_q;
   assign bus.cout_ctl_data_wr = cout_wr_q;
   assign bus.cout_ctl_ready   = 1'b1;
endmodule

// File: tb/tb_ctl_master.sv
// Directed bench for ctl_master: writes, reads, no-responder, timeout,
// backpressure, seq wrap and mid-operation reset.
module tb_ctl_master;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;
   logic [133:0] hdr_obs;
   logic         seen;

   localparam logic [133:0] TAIL   = {2'b10, 132'h0};
   localparam logic [133:0] WR_HDR = {2'b01, 4'h0, 4'h2, 12'h001, 8'h01, 8'h07,
                                      32'h70000003, 32'h0, 32'h00000011};

   always #5 clk = ~clk;

   ctl_master_if bus_if ();

   ctl_master #(.OWN_MID(8'd1), .TIMEOUT(16'd16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.master)
   );

   function automatic logic [133:0] mk(input logic [3:0] typ, input logic [11:0] seq,
                                       input logic [7:0] src, input logic [7:0] dst,
                                       input logic [31:0] addr, input logic [31:0] data);
      return {2'b01, 4'h0, typ, seq, src, dst, addr, 32'h0, data};
   endfunction

   task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_in();
      bus_if.req_valid       = 1'b0;
      bus_if.req_write       = 1'b0;
      bus_if.req_dst_mid     = 8'h0;
      bus_if.req_addr        = 32'h0;
      bus_if.req_wdata       = 32'h0;
      bus_if.cin_ctl_ready   = 1'b1;
      bus_if.cin_ctl_data    = 134'h0;
      bus_if.cin_ctl_data_wr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_in();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic req(input logic wr, input logic [7:0] dst, input logic [31:0] addr,
                      input logic [31:0] wdata);
      bus_if.req_valid   = 1'b1;
      bus_if.req_write   = wr;
      bus_if.req_dst_mid = dst;
      bus_if.req_addr    = addr;
      bus_if.req_wdata   = wdata;
   endtask

   task automatic ring_in(input logic [133:0] flit);
      bus_if.cin_ctl_data    = flit;
      bus_if.cin_ctl_data_wr = 1'b1;
   endtask

   task automatic ring_off();
      bus_if.cin_ctl_data    = 134'h0;
      bus_if.cin_ctl_data_wr = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] dst, input logic [31:0] addr,
                           input logic [31:0] wdata);
      req(1'b1, dst, addr, wdata);
      cyc();
      bus_if.req_valid = 1'b0;
      cyc();
      hdr_obs = bus_if.cout_ctl_data;
      cyc();
   endtask

   initial begin
      // Reset values.
      do_reset();
      chk("rst_req_ready", 134'(bus_if.req_ready), 134'(1'b1));
      chk("rst_cout_ready", 134'(bus_if.cout_ctl_ready), 134'(1'b1));
      chk("rst_rsp_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      chk("rst_rsp_err", 134'(bus_if.rsp_err), 134'(2'b00));
      chk("rst_rsp_rdata", 134'(bus_if.rsp_rdata), 134'(32'h0));
      chk("rst_cout_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      chk("rst_cout_data", bus_if.cout_ctl_data, 134'h0);

      // Write; req inputs scrambled after acceptance must not matter.
      req(1'b1, 8'h07, 32'h70000003, 32'h00000011);
      cyc();
      bus_if.req_valid   = 1'b0;
      bus_if.req_write   = 1'b0;
      bus_if.req_dst_mid = 8'h55;
      bus_if.req_addr    = 32'hFFFFFFFF;
      bus_if.req_wdata   = 32'hAAAAAAAA;
      chk("wr_c1_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      chk("wr_c1_ready", 134'(bus_if.req_ready), 134'(1'b0));
      cyc();
      chk("wr_hdr_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b1));
      chk("wr_hdr", bus_if.cout_ctl_data, WR_HDR);
      chk("wr_c2_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      cyc();
      chk("wr_tail_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b1));
      chk("wr_tail", bus_if.cout_ctl_data, TAIL);
      chk("wr_rsp_valid", 134'(bus_if.rsp_valid), 134'(1'b1));
      chk("wr_rsp_err", 134'(bus_if.rsp_err), 134'(2'b00));
      chk("wr_rsp_rdata", 134'(bus_if.rsp_rdata), 134'(32'h0));
      chk("wr_c3_ready", 134'(bus_if.req_ready), 134'(1'b1));
      cyc();
      chk("wr_c4_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      chk("wr_c4_data", bus_if.cout_ctl_data, 134'h0);
      chk("wr_c4_valid", 134'(bus_if.rsp_valid), 134'(1'b0));

      // Read with a matching response.
      do_reset();
      req(1'b0, 8'h07, 32'h70000002, 32'h0);
      cyc();
      bus_if.req_valid = 1'b0;
      cyc();
      chk("rd_hdr", bus_if.cout_ctl_data, mk(4'h1, 12'h001, 8'h01, 8'h07, 32'h70000002, 32'h0));
      cyc();
      chk("rd_tail", bus_if.cout_ctl_data, TAIL);
      chk("rd_c3_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      chk("rd_c3_ready", 134'(bus_if.req_ready), 134'(1'b0));
      ring_in(mk(4'hB, 12'h001, 8'h07, 8'h01, 32'h70000002, 32'hDEADBEEF));
      cyc();
      ring_in(TAIL);
      chk("rd_c4_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      cyc();
      ring_off();
      chk("rd_rsp_valid", 134'(bus_if.rsp_valid), 134'(1'b1));
      chk("rd_rsp_err", 134'(bus_if.rsp_err), 134'(2'b00));
      chk("rd_rsp_rdata", 134'(bus_if.rsp_rdata), 134'(32'hDEADBEEF));
      chk("rd_ready", 134'(bus_if.req_ready), 134'(1'b1));
      cyc();
      chk("rd_c6_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      chk("rd_hold_rdata", 134'(bus_if.rsp_rdata), 134'(32'hDEADBEEF));

      // No responder, preceded by a foreign packet with the wrong seq.
      do_reset();
      req(1'b0, 8'h09, 32'h90000010, 32'h0);
      cyc();
      bus_if.req_valid = 1'b0;
      cyc();
      cyc();
      ring_in(mk(4'hB, 12'h005, 8'h09, 8'h01, 32'h90000010, 32'h00001234));
      cyc();
      ring_in(TAIL);
      cyc();
      chk("nr_stray_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      ring_in(mk(4'h1, 12'h001, 8'h01, 8'h09, 32'h90000010, 32'h0));
      cyc();
      ring_in(TAIL);
      cyc();
      ring_off();
      chk("nr_rsp_valid", 134'(bus_if.rsp_valid), 134'(1'b1));
      chk("nr_rsp_err", 134'(bus_if.rsp_err), 134'(2'b10));
      chk("nr_rsp_rdata", 134'(bus_if.rsp_rdata), 134'(32'h0));

      // Timeout exactly 17 cycles after the tail, then a late response.
      do_reset();
      req(1'b0, 8'h07, 32'h70000002, 32'h0);
      cyc();
      bus_if.req_valid = 1'b0;
      cyc();
      cyc();
      chk("to_tail", bus_if.cout_ctl_data, TAIL);
      for (int c = 4; c <= 19; c++) begin
         cyc();
         chk("to_wait_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      end
      cyc();
      chk("to_rsp_valid", 134'(bus_if.rsp_valid), 134'(1'b1));
      chk("to_rsp_err", 134'(bus_if.rsp_err), 134'(2'b01));
      chk("to_rsp_rdata", 134'(bus_if.rsp_rdata), 134'(32'h0));
      chk("to_ready", 134'(bus_if.req_ready), 134'(1'b1));
      ring_in(mk(4'hB, 12'h001, 8'h07, 8'h01, 32'h70000002, 32'hCAFEF00D));
      cyc();
      ring_in(TAIL);
      chk("late_c21_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      cyc();
      ring_off();
      chk("late_c22_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      cyc();
      chk("late_c23_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      chk("late_err_hold", 134'(bus_if.rsp_err), 134'(2'b01));

      // Response tail on the timeout cycle wins; all-ones is ordinary data.
      do_reset();
      req(1'b0, 8'h07, 32'h70000004, 32'h0);
      cyc();
      bus_if.req_valid = 1'b0;
      cyc();
      cyc();
      ring_in(mk(4'hB, 12'h001, 8'h07, 8'h01, 32'h70000004, 32'hFFFFFFFF));
      cyc();
      ring_off();
      for (int c = 5; c <= 19; c++) begin
         cyc();
         chk("tt_wait_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      end
      ring_in(TAIL);
      cyc();
      ring_off();
      chk("tt_rsp_valid", 134'(bus_if.rsp_valid), 134'(1'b1));
      chk("tt_rsp_err", 134'(bus_if.rsp_err), 134'(2'b00));
      chk("tt_rsp_rdata", 134'(bus_if.rsp_rdata), 134'(32'hFFFFFFFF));

      // Backpressure: 3 cycles in SEND_HDR, 2 cycles in SEND_TAIL.
      do_reset();
      req(1'b1, 8'h03, 32'h30000000, 32'h00000005);
      cyc();
      bus_if.req_valid     = 1'b0;
      bus_if.cin_ctl_ready = 1'b0;
      chk("bp_c1_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      cyc();
      chk("bp_c2_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      chk("bp_c2_data", bus_if.cout_ctl_data, 134'h0);
      cyc();
      chk("bp_c3_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      cyc();
      chk("bp_c4_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      bus_if.cin_ctl_ready = 1'b1;
      cyc();
      chk("bp_hdr_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b1));
      chk("bp_hdr", bus_if.cout_ctl_data, mk(4'h2, 12'h001, 8'h01, 8'h03, 32'h30000000, 32'h5));
      bus_if.cin_ctl_ready = 1'b0;
      cyc();
      chk("bp_c6_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      chk("bp_c6_data", bus_if.cout_ctl_data, 134'h0);
      cyc();
      chk("bp_c7_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      bus_if.cin_ctl_ready = 1'b1;
      cyc();
      chk("bp_tail_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b1));
      chk("bp_tail", bus_if.cout_ctl_data, TAIL);
      chk("bp_rsp_valid", 134'(bus_if.rsp_valid), 134'(1'b1));
      cyc();
      chk("bp_c9_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));

      // seq wrap over 4096 writes.
      do_reset();
      for (int i = 0; i < 4094; i++) do_write(8'h02, 32'h20000000, 32'h0);
      do_write(8'h02, 32'h20000000, 32'h0);
      chk("wrap_seq_fff", 134'(hdr_obs[123:112]), 134'(12'hFFF));
      do_write(8'h04, 32'h40000008, 32'h00000099);
      chk("wrap_seq_000", hdr_obs, mk(4'h2, 12'h000, 8'h01, 8'h04, 32'h40000008, 32'h99));
      do_write(8'h02, 32'h20000000, 32'h0);
      chk("wrap_seq_001", 134'(hdr_obs[123:112]), 134'(12'h001));

      // Reset while waiting for a read response.
      do_reset();
      req(1'b0, 8'h07, 32'h70000002, 32'h0);
      cyc();
      bus_if.req_valid = 1'b0;
      for (int c = 2; c <= 5; c++) cyc();
      rst = 1'b1;
      #1;
      chk("mr_ready", 134'(bus_if.req_ready), 134'(1'b1));
      chk("mr_valid", 134'(bus_if.rsp_valid), 134'(1'b0));
      chk("mr_cout_wr", 134'(bus_if.cout_ctl_data_wr), 134'(1'b0));
      chk("mr_cout_data", bus_if.cout_ctl_data, 134'h0);
      cyc();
      rst  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 24; c++) begin
         cyc();
         seen = seen | bus_if.rsp_valid;
      end
      chk("mr_no_rsp_valid", 134'(seen), 134'(1'b0));
      do_write(8'h07, 32'h70000005, 32'h00000022);
      chk("mr_next_seq", hdr_obs, mk(4'h2, 12'h001, 8'h01, 8'h07, 32'h70000005, 32'h22));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
